vga_timing_pipe: RTL and testbench



---
 rtl/vga_timing_pipe_if.sv | 39 +++
 rtl/vga_timing_pipe.sv | 135 +++++++++++++
 tb/tb_vga_timing_pipe.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pipe_if.sv
// rtl/vga_timing_pipe_if.sv - timing/coordinate bundle driven by vga_timing_pipe
//
// Signals (master drives, slave receives):
//   oHS, oVS     sync levels, already polarity-adjusted
//   visible      active-video flag
//   p_tick       pixel-enable pulse
//   line_start   pulse on the pixel tick at h=0
//   frame_start  pulse on the pixel tick at h=0, v=0
//   pixel_x/y    current coordinates (CW bits)
//   frame_cnt    16-bit frame counter, present only with VGA_TIMING_FRAME_CNT_EN
interface vga_timing_pipe_if #(
  parameter int CW = 10
);
  logic          oHS;
  logic          oVS;
  logic          visible;
  logic          p_tick;
  logic          line_start;
  logic          frame_start;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  modport master (
    output oHS, oVS, visible, p_tick, line_start, frame_start, pixel_x, pixel_y
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input oHS, oVS, visible, p_tick, line_start, frame_start, pixel_x, pixel_y
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - parametrised VGA timing generator with output alignment pipeline
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   vga    vga_timing_pipe_if.master: sync/visible/tick/start flags delayed DELAY clks,
//          pixel_x/pixel_y registered with 1-clk latency
// Optional: define VGA_TIMING_FRAME_CNT_EN to add vga.frame_cnt (16-bit frame counter).
module vga_timing_pipe #(
  parameter int PIX_DIV  = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int DELAY    = 2,
  parameter int CW       = 10
) (
  input  logic               clk,
  input  logic               reset,
  vga_timing_pipe_if.master  vga
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISP);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISP);
  // Inclusive end points so the bound always fits in CW bits even with a zero back porch.
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISP + V_FP + V_SYNC - 1);

  // Pipeline lane order: {hs, vs, vis, tick, line_start, frame_start}
  localparam logic [5:0] PIPE_RST = {~SYNC_POL, ~SYNC_POL, 4'b0000};

  logic [DW-1:0] div;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          t;
  logic          hs_act;
  logic          vs_act;
  logic          vis;
  logic          ls;
  logic          fs;
  logic [5:0]    raw_vec;
  logic [5:0]    pipe [DELAY];

  // With PIX_DIV=1 div is stuck at 0 and DIV_LAST is 0, so t is constantly high.
  always_comb begin
    t       = (div == DIV_LAST);
    hs_act  = (h >= HS_FIRST) && (h <= HS_LAST);
    vs_act  = (v >= VS_FIRST) && (v <= VS_LAST);
    vis     = (h < H_VIS) && (v < V_VIS);
    ls      = t && (h == '0);
    fs      = ls && (v == '0);
    raw_vec = {hs_act ? SYNC_POL : ~SYNC_POL,
               vs_act ? SYNC_POL : ~SYNC_POL,
               vis, t, ls, fs};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      h       <= '0;
      v       <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      div     <= t ? '0 : div + DW'(1);
      pixel_x <= h;
      pixel_y <= v;
      if (t) begin
        h <= (h == H_LAST) ? '0 : h + CW'(1);
        if (h == H_LAST) begin
          v <= (v == V_LAST) ? '0 : v + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe[i] <= PIPE_RST;
      end
    end else begin
      pipe[0] <= raw_vec;
      for (int i = 1; i < DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign vga.oHS         = pipe[DELAY-1][5];
  assign vga.oVS         = pipe[DELAY-1][4];
  assign vga.visible     = pipe[DELAY-1][3];
  assign vga.p_tick      = pipe[DELAY-1][2];
  assign vga.line_start  = pipe[DELAY-1][1];
  assign vga.frame_start = pipe[DELAY-1][0];
  assign vga.pixel_x     = pixel_x;
  assign vga.pixel_y     = pixel_y;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic        fs_seen;

  // The first frame start after reset opens frame 0; later ones advance the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      fs_seen   <= 1'b0;
    end else if (fs) begin
      fs_seen <= 1'b1;
      if (fs_seen) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign vga.frame_cnt = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb/tb_vga_timing_pipe.sv - self-checking bench for vga_timing_pipe
module tb_vga_timing_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   fcnt_b   = 0;

  always #5 clk = ~clk;

  // a: small timing, divider 4, delay 2
  vga_timing_pipe_if #(.CW(4)) a_if ();
  vga_timing_pipe #(
    .PIX_DIV(4), .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .DELAY(2), .CW(4)
  ) dut_a (.clk(clk), .reset(reset), .vga(a_if));

  // b: small timing, no divider, delay 3
  vga_timing_pipe_if #(.CW(4)) b_if ();
  vga_timing_pipe #(
    .PIX_DIV(1), .H_DISP(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .DELAY(3), .CW(4)
  ) dut_b (.clk(clk), .reset(reset), .vga(b_if));

  // c: default 640x480 timing
  vga_timing_pipe_if #(.CW(10)) c_if ();
  vga_timing_pipe dut_c (.clk(clk), .reset(reset), .vga(c_if));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Expected raw flags {hs, vs, vis, tick, ls, fs} j clks after reset release (active-low sync).
  function automatic logic [5:0] exp_raw(int j, int p, int hd, int hf, int hs, int hb,
                                         int vd, int vf, int vs, int vb);
    int  ht, vt, n, h, v;
    logic t, hsa, vsa, vis;
    if (j < 0) return 6'b110000;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    n   = j / p;
    h   = n % ht;
    v   = (n / ht) % vt;
    t   = ((j % p) == p - 1);
    hsa = (h >= hd + hf) && (h < hd + hf + hs);
    vsa = (v >= vd + vf) && (v < vd + vf + vs);
    vis = (h < hd) && (v < vd);
    return {~hsa, ~vsa, vis, t, t && h == 0, t && h == 0 && v == 0};
  endfunction

  function automatic int exp_x(int j, int p, int ht);
    return (j < 0) ? 0 : (j / p) % ht;
  endfunction

  function automatic int exp_y(int j, int p, int ht, int vt);
    return (j < 0) ? 0 : ((j / p) / ht) % vt;
  endfunction

  task automatic check_cycle(input string nm, input int k, input int p, input int d,
                             input int hd, input int hf, input int hs, input int hb,
                             input int vd, input int vf, input int vs, input int vb,
                             input logic [5:0] flags, input int px, input int py);
    int ht, vt;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    check($sformatf("%s_flags_k%0d", nm, k), 32'(flags),
          32'(exp_raw(k - d, p, hd, hf, hs, hb, vd, vf, vs, vb)));
    check($sformatf("%s_x_k%0d", nm, k), px, exp_x(k - 1, p, ht));
    check($sformatf("%s_y_k%0d", nm, k), py, exp_y(k - 1, p, ht, vt));
  endtask

  task automatic check_reset_state(input string phase);
    check({phase, "_a_flags"}, 32'({a_if.oHS, a_if.oVS, a_if.visible, a_if.p_tick,
                                    a_if.line_start, a_if.frame_start}), 32'h30);
    check({phase, "_b_flags"}, 32'({b_if.oHS, b_if.oVS, b_if.visible, b_if.p_tick,
                                    b_if.line_start, b_if.frame_start}), 32'h30);
    check({phase, "_c_flags"}, 32'({c_if.oHS, c_if.oVS, c_if.visible, c_if.p_tick,
                                    c_if.line_start, c_if.frame_start}), 32'h30);
    check({phase, "_c_xy"}, {6'd0, c_if.pixel_x, 6'd0, c_if.pixel_y}, 32'd0);
    check({phase, "_a_xy"}, 32'({a_if.pixel_x, a_if.pixel_y}), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check({phase, "_b_fcnt"}, 32'(b_if.frame_cnt), 32'd0);
`endif
  endtask

  // Runs n clks after reset release; sampled on the falling edge.
  task automatic run_cycles(input int n);
    fcnt_b = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check_cycle("a", k, 4, 2, 8, 1, 2, 1, 4, 1, 1, 1,
                  {a_if.oHS, a_if.oVS, a_if.visible, a_if.p_tick, a_if.line_start, a_if.frame_start},
                  int'(a_if.pixel_x), int'(a_if.pixel_y));
      check_cycle("b", k, 1, 3, 8, 1, 2, 1, 4, 1, 1, 1,
                  {b_if.oHS, b_if.oVS, b_if.visible, b_if.p_tick, b_if.line_start, b_if.frame_start},
                  int'(b_if.pixel_x), int'(b_if.pixel_y));
      check_cycle("c", k, 4, 2, 640, 16, 96, 48, 480, 10, 2, 33,
                  {c_if.oHS, c_if.oVS, c_if.visible, c_if.p_tick, c_if.line_start, c_if.frame_start},
                  int'(c_if.pixel_x), int'(c_if.pixel_y));
      // Hand-computed landmarks
      if (k == 4)    check("a_tick_before_first", 32'(a_if.p_tick), 32'd0);
      if (k == 5)    check("a_first_tick_fs", 32'({a_if.p_tick, a_if.frame_start}), 32'd3);
      if (k == 6)    check("a_tick_width", 32'(a_if.p_tick), 32'd0);
      if (k == 9)    check("a_tick_period", 32'(a_if.p_tick), 32'd1);
      if (k == 341)  check("a_second_frame_start", 32'(a_if.frame_start), 32'd1);
      if (k == 2)    check("b_tick_before_3", 32'(b_if.p_tick), 32'd0);
      if (k == 3)    check("b_first_fs", 32'({b_if.p_tick, b_if.frame_start}), 32'd3);
      if (k == 12)   check("b_hs_low_x9", 32'(b_if.oHS), 32'd0);
      if (k == 14)   check("b_hs_high_x11", 32'(b_if.oHS), 32'd1);
      if (k == 87)   check("b_second_frame_start", 32'(b_if.frame_start), 32'd1);
      if (k == 1202) check("c_x_at_300", 32'(c_if.pixel_x), 32'd300);
      if (k == 2625) check("c_hs_high_before_656", 32'(c_if.oHS), 32'd1);
      if (k == 2626) check("c_hs_low_at_656", 32'(c_if.oHS), 32'd0);
      if (k == 3009) check("c_hs_low_at_751", 32'(c_if.oHS), 32'd0);
      if (k == 3010) check("c_hs_high_at_752", 32'(c_if.oHS), 32'd1);
      if (k == 3205) check("c_second_line_start", 32'({c_if.line_start, c_if.frame_start}), 32'd2);
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (b_if.frame_start) begin
        check($sformatf("b_fcnt_frame%0d", fcnt_b), 32'(b_if.frame_cnt), 32'(fcnt_b));
        fcnt_b++;
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    run_cycles(1202);

    // Single-clk reset in the middle of a line, then a full restart.
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    reset = 1'b0;
    run_cycles(7000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
